// File: rtl/clk_en_rst_seq.sv
// Clock-enable and reset sequencer: a free-running sideband strobe, a held core reset,
// and per-lane strobes whose rate follows the active link generation.
module clk_en_rst_seq #(
   parameter int         NUM_LANES   = 2,
   parameter int         SB_DIV      = 16,
   parameter int         GEN2_DIV    = 8,
   parameter int         GEN3_DIV    = 4,
   parameter int         GEN4_DIV    = 2,
   parameter int         RST_HOLD    = 3,
   parameter int         SWITCH_GAP  = 4,
   parameter logic [1:0] GEN_DEFAULT = 2'b11
) (
   input  logic                 local_clk,
   input  logic                 rst,
   input  logic                 lane_disable,
   input  logic                 gen_req,
   input  logic [1:0]           gen_sel,
   output logic                 gen_ack,
   output logic [1:0]           gen_cur,
   output logic                 sb_en,
   output logic [NUM_LANES-1:0] lane_en,
   output logic                 core_rst_n,
   output logic                 switching
);

   localparam logic [1:0] ST_HOLD   = 2'b00;
   localparam logic [1:0] ST_RUN    = 2'b01;
   localparam logic [1:0] ST_SWITCH = 2'b10;

   localparam int LANE_MAX = (GEN2_DIV > GEN3_DIV) ?
                             ((GEN2_DIV > GEN4_DIV) ? GEN2_DIV : GEN4_DIV) :
                             ((GEN3_DIV > GEN4_DIV) ? GEN3_DIV : GEN4_DIV);
   localparam int SBW = $clog2(SB_DIV);
   localparam int LW  = $clog2(LANE_MAX);
   localparam int HW  = $clog2(RST_HOLD + 1);
   localparam int SWW = $clog2(SWITCH_GAP + 1);

   localparam logic [SBW-1:0] SB_LAST   = SBW'(SB_DIV - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_HOLD - 1);
   localparam logic [SWW-1:0] SW_LAST   = SWW'(SWITCH_GAP - 1);

   logic [1:0]           state_r, state_nx_s;
   logic [SBW-1:0]       sb_cnt_r, sb_cnt_nx_s;
   logic [HW-1:0]        hold_cnt_r, hold_cnt_nx_s;
   logic [LW-1:0]        lane_cnt_r, lane_cnt_nx_s;
   logic [SWW-1:0]       sw_cnt_r, sw_cnt_nx_s;
   logic [1:0]           gen_cur_r, gen_cur_nx_s;
   logic [1:0]           gen_lat_r, gen_lat_nx_s;
   logic                 ack_nx_s;
   logic [NUM_LANES-1:0] lane_mask_s;
   logic [NUM_LANES-1:0] lane_en_nx_s;
   logic                 sb_en_r;
   logic [NUM_LANES-1:0] lane_en_r;
   logic                 core_rst_n_r;
   logic                 gen_ack_r;
   logic                 switching_r;

   // Terminal lane-counter value for a given generation
   function automatic logic [LW-1:0] div_last(input logic [1:0] gen);
      logic [LW-1:0] last;
      case (gen)
         2'b01:   last = LW'(GEN2_DIV - 1);
         2'b10:   last = LW'(GEN3_DIV - 1);
         2'b11:   last = LW'(GEN4_DIV - 1);
         default: last = LW'(GEN4_DIV - 1);
      endcase
      return last;
   endfunction

   // Next-state and next-output computation; outputs are registered from these values
   always_comb begin
      state_nx_s    = state_r;
      hold_cnt_nx_s = hold_cnt_r;
      lane_cnt_nx_s = lane_cnt_r;
      sw_cnt_nx_s   = sw_cnt_r;
      gen_cur_nx_s  = gen_cur_r;
      gen_lat_nx_s  = gen_lat_r;
      ack_nx_s      = 1'b0;
      lane_mask_s   = '0;
      lane_en_nx_s  = '0;

      if (sb_cnt_r == SB_LAST) begin
         sb_cnt_nx_s = '0;
      end else begin
         sb_cnt_nx_s = sb_cnt_r + 1'b1;
      end

      case (state_r)
         ST_HOLD: begin
            lane_cnt_nx_s = '0;
            if (sb_en_r) begin
               if (hold_cnt_r == HOLD_LAST) begin
                  state_nx_s    = ST_RUN;
                  hold_cnt_nx_s = '0;
               end else begin
                  hold_cnt_nx_s = hold_cnt_r + 1'b1;
               end
            end else begin
               hold_cnt_nx_s = hold_cnt_r;
            end
         end
         ST_RUN: begin
            if (lane_cnt_r == div_last(gen_cur_r)) begin
               lane_cnt_nx_s = '0;
            end else begin
               lane_cnt_nx_s = lane_cnt_r + 1'b1;
            end
            // A request for an invalid or already-active generation is acked without a switch
            if (gen_req) begin
               if ((gen_sel != 2'b00) && (gen_sel != gen_cur_r)) begin
                  state_nx_s    = ST_SWITCH;
                  gen_lat_nx_s  = gen_sel;
                  lane_cnt_nx_s = '0;
                  sw_cnt_nx_s   = '0;
               end else begin
                  ack_nx_s = 1'b1;
               end
            end else begin
               ack_nx_s = 1'b0;
            end
         end
         ST_SWITCH: begin
            lane_cnt_nx_s = '0;
            if (sw_cnt_r == SW_LAST) begin
               state_nx_s   = ST_RUN;
               gen_cur_nx_s = gen_lat_r;
               sw_cnt_nx_s  = '0;
               ack_nx_s     = 1'b1;
            end else begin
               sw_cnt_nx_s = sw_cnt_r + 1'b1;
            end
         end
         default: begin
            state_nx_s    = ST_HOLD;
            hold_cnt_nx_s = '0;
            lane_cnt_nx_s = '0;
            sw_cnt_nx_s   = '0;
            gen_cur_nx_s  = GEN_DEFAULT;
         end
      endcase

      for (int i = 0; i < NUM_LANES; i++) begin
         lane_mask_s[i] = (i == 0) ? 1'b1 : ~lane_disable;
      end

      if ((state_nx_s == ST_RUN) && (lane_cnt_nx_s == div_last(gen_cur_nx_s))) begin
         lane_en_nx_s = lane_mask_s;
      end else begin
         lane_en_nx_s = '0;
      end
   end

   // State, counters and registered outputs with synchronous active-low reset
   always_ff @(posedge local_clk) begin
      if (!rst) begin
         state_r      <= ST_HOLD;
         sb_cnt_r     <= '0;
         hold_cnt_r   <= '0;
         lane_cnt_r   <= '0;
         sw_cnt_r     <= '0;
         gen_cur_r    <= GEN_DEFAULT;
         gen_lat_r    <= GEN_DEFAULT;
         sb_en_r      <= 1'b0;
         lane_en_r    <= '0;
         core_rst_n_r <= 1'b0;
         gen_ack_r    <= 1'b0;
         switching_r  <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         sb_cnt_r     <= sb_cnt_nx_s;
         hold_cnt_r   <= hold_cnt_nx_s;
         lane_cnt_r   <= lane_cnt_nx_s;
         sw_cnt_r     <= sw_cnt_nx_s;
         gen_cur_r    <= gen_cur_nx_s;
         gen_lat_r    <= gen_lat_nx_s;
         sb_en_r      <= (sb_cnt_nx_s == SB_LAST);
         lane_en_r    <= lane_en_nx_s;
         core_rst_n_r <= (state_nx_s != ST_HOLD);
         gen_ack_r    <= ack_nx_s;
         switching_r  <= (state_nx_s == ST_SWITCH);
      end
   end

   assign sb_en      = sb_en_r;
   assign lane_en    = lane_en_r;
   assign core_rst_n = core_rst_n_r;
   assign gen_ack    = gen_ack_r;
   assign switching  = switching_r;
   assign gen_cur    = gen_cur_r;

endmodule

// File: tb/tb_clk_en_rst_seq.sv
// Directed bench for clk_en_rst_seq: reset/hold sequence, lane cadence, lane disable,
// generation switch and no-op requests, and reset in the middle of a switch.
module tb_clk_en_rst_seq;

   logic       local_clk;
   logic       rst;
   logic       lane_disable;
   logic       gen_req;
   logic [1:0] gen_sel;
   logic       gen_ack;
   logic [1:0] gen_cur;
   logic       sb_en;
   logic [1:0] lane_en;
   logic       core_rst_n;
   logic       switching;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic       dis;
      logic       req;
      logic [1:0] sel;
      logic [1:0] lane;
      logic       ack;
      logic       sw;
      logic [1:0] cur;
   } vec_t;

   vec_t tbl [31];

   clk_en_rst_seq dut (
      .local_clk    (local_clk),
      .rst          (rst),
      .lane_disable (lane_disable),
      .gen_req      (gen_req),
      .gen_sel      (gen_sel),
      .gen_ack      (gen_ack),
      .gen_cur      (gen_cur),
      .sb_en        (sb_en),
      .lane_en      (lane_en),
      .core_rst_n   (core_rst_n),
      .switching    (switching)
   );

   initial begin
      local_clk = 1'b0;
      forever #5 local_clk = ~local_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge local_clk);
      #1;
      cyc++;
   endtask

   task automatic chk_reset_vals();
      chk("rst_sb_en",      32'(sb_en),      32'd0);
      chk("rst_lane_en",    32'(lane_en),    32'd0);
      chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("rst_gen_ack",    32'(gen_ack),    32'd0);
      chk("rst_switching",  32'(switching),  32'd0);
      chk("rst_gen_cur",    32'(gen_cur),    32'd3);
   endtask

   // 60 cycles from reset release: hold for three sideband strobes, then Gen4 lane strobes
   task automatic hold_phase(input bit with_req);
      for (int n = 0; n < 60; n++) begin
         chk("hold_sb_en",      32'(sb_en),      32'((n % 16) == 15));
         chk("hold_core_rst_n", 32'(core_rst_n), 32'(n >= 48));
         chk("hold_lane_en",    32'(lane_en),    ((n >= 49) && (n % 2 == 1)) ? 32'd3 : 32'd0);
         chk("hold_gen_ack",    32'(gen_ack),    32'd0);
         chk("hold_switching",  32'(switching),  32'd0);
         chk("hold_gen_cur",    32'(gen_cur),    32'd3);
         gen_req = with_req && (n < 45) && ((n % 5) == 2);
         gen_sel = 2'b01;
         step();
      end
      gen_req = 1'b0;
   endtask

   initial begin
      // Cycles 60..90 relative to reset release
      tbl[0]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11};
      tbl[1]  = '{1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 2'b11};
      tbl[2]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11};
      tbl[3]  = '{1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 2'b11};
      tbl[4]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11};
      tbl[5]  = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 2'b11};
      tbl[6]  = '{1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b11};
      tbl[7]  = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 2'b11};
      tbl[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11};
      tbl[9]  = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 2'b11};
      tbl[10] = '{1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b11};
      tbl[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11};
      tbl[12] = '{1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 2'b11};
      tbl[13] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11};
      tbl[14] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11};
      tbl[15] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
      for (int i = 16; i < 31; i++) begin
         tbl[i] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01};
      end
      tbl[22].lane = 2'b11;
      tbl[30].lane = 2'b11;

      rst          = 1'b0;
      lane_disable = 1'b0;
      gen_req      = 1'b0;
      gen_sel      = 2'b00;
      step();
      step();
      cyc = 0;
      chk_reset_vals();
      rst = 1'b1;

      hold_phase(1'b0);

      for (int i = 0; i < 31; i++) begin
         chk("tbl_sb_en",     32'(sb_en),     32'((cyc % 16) == 15));
         chk("tbl_lane_en",   32'(lane_en),   32'(tbl[i].lane));
         chk("tbl_gen_ack",   32'(gen_ack),   32'(tbl[i].ack));
         chk("tbl_switching", 32'(switching), 32'(tbl[i].sw));
         chk("tbl_gen_cur",   32'(gen_cur),   32'(tbl[i].cur));
         chk("tbl_core_rst_n", 32'(core_rst_n), 32'd1);
         lane_disable = tbl[i].dis;
         gen_req      = tbl[i].req;
         gen_sel      = tbl[i].sel;
         step();
      end

      // Cycle 91: Gen2 running; request Gen4 then reset during the second switch cycle
      lane_disable = 1'b0;
      chk("seq_lane_en_c91", 32'(lane_en),   32'd0);
      chk("seq_gen_cur_c91", 32'(gen_cur),   32'd1);
      chk("seq_sw_c91",      32'(switching), 32'd0);
      gen_req = 1'b1;
      gen_sel = 2'b11;
      step();
      chk("seq_sw_c92",      32'(switching), 32'd1);
      chk("seq_lane_en_c92", 32'(lane_en),   32'd0);
      gen_req = 1'b0;
      step();
      chk("seq_sw_c93",      32'(switching), 32'd1);
      chk("seq_gen_cur_c93", 32'(gen_cur),   32'd1);
      rst = 1'b0;
      step();
      cyc = 0;
      chk_reset_vals();
      rst = 1'b1;

      // Requests issued while holding must neither ack nor change the generation
      hold_phase(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
